axis_ctrlsrc_offset_cal: RTL and testbench

//  Auto-zero sequencer for the control-source select stage. On request it freezes the servo,

---
 rtl/axis_ctrlsrc_offset_cal_if.sv | 37 +++
 rtl/axis_ctrlsrc_offset_cal.sv | 269 ++++++++++++++++++++++++++
 tb/tb_axis_ctrlsrc_offset_cal.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ctrlsrc_offset_cal_if.sv
// ---------------------------------------------------------------------------
// axis_ctrlsrc_offset_cal_if
//
// Purpose:
//   Minimal AXI-Stream style sample bus carrying the raw signed samples that
//   feed both the control-source select stage and the offset calibrator.
//   The stream has no back-pressure, so there is no tready.
//
// Parameters:
//   DATA_WIDTH  width of tdata (signed sample)
//
// Signals:
//   tdata   raw signed sample
//   tvalid  sample valid
//
// Modports:
//   master  drives tdata/tvalid (sample producer)
//   slave   observes tdata/tvalid (calibrator, select stage)
// ---------------------------------------------------------------------------
interface axis_ctrlsrc_offset_cal_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;

  modport master (
    output tdata,
    output tvalid
  );

  modport slave (
    input tdata,
    input tvalid
  );

endinterface

// File: rtl/axis_ctrlsrc_offset_cal.sv
// ---------------------------------------------------------------------------
// axis_ctrlsrc_offset_cal
//
// Purpose:
//   Auto-zero sequencer for the control-source select stage. On request it
//   freezes the servo (hold_ctrl), forces the selector onto the linear path,
//   averages 2^n raw input samples and then writes signal_offset = -average,
//   so that the select stage's offset adder nulls the input. While no
//   calibration is running the host may write signal_offset directly.
//
//   Sequence: IDLE -> HOLD (settle) -> ACCUM (collect 2^n samples)
//             -> COMPUTE (average, negate, saturate) -> APPLY (commit) -> IDLE
//
// Parameters:
//   DATA_WIDTH   width of raw sample, offset_in and signal_offset (signed)
//   MAX_LOG2     upper clamp for log2_n (must be <= 31); the accumulator is
//                DATA_WIDTH+MAX_LOG2 bits wide so it can never overflow
//   TIMEOUT_CYC  consecutive no-sample cycles tolerated in ACCUM; only used
//                when CTRLSRC_CAL_TIMEOUT_EN is defined
//
// Build option:
//   CTRLSRC_CAL_TIMEOUT_EN  when defined, a stall counter aborts ACCUM after
//                           TIMEOUT_CYC consecutive cycles without tvalid and
//                           raises the sticky cal_error flag. When undefined,
//                           ACCUM waits forever and cal_error is tied low.
//
// Ports:
//   a_clk             in   clock
//   aresetn           in   synchronous reset, active low
//   S_AXIS            slave  raw sample stream (tdata, tvalid), no back-pressure
//   cal_start         in   one-cycle request to start a calibration (IDLE only)
//   cal_abort         in   cancel a calibration in HOLD/ACCUM/COMPUTE
//   log2_n            in   sample count exponent, clamped to MAX_LOG2
//   settle_cycles     in   servo settle time before accumulation
//   offset_wr         in   manual offset write strobe (IDLE only)
//   offset_in         in   manual offset value
//   selection_ln_in   in   host lin/log selection
//   selection_ln_out  out  busy ? 2'b00 : selection_ln_in (combinational)
//   signal_offset     out  offset to the select stage (registered)
//   hold_ctrl         out  servo freeze, equal to busy
//   busy              out  high in any state other than IDLE
//   done              out  one-cycle pulse when a calibrated offset is applied
//   cal_error         out  sticky timeout flag (0 without the build option)
//   state_mon         out  IDLE=0 HOLD=1 ACCUM=2 COMPUTE=3 APPLY=4
// ---------------------------------------------------------------------------
module axis_ctrlsrc_offset_cal #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_LOG2    = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  a_clk,
  input  logic                  aresetn,
  axis_ctrlsrc_offset_cal_if.slave S_AXIS,
  input  logic                  cal_start,
  input  logic                  cal_abort,
  input  logic [4:0]            log2_n,
  input  logic [15:0]           settle_cycles,
  input  logic                  offset_wr,
  input  logic [DATA_WIDTH-1:0] offset_in,
  input  logic [1:0]            selection_ln_in,
  output logic [1:0]            selection_ln_out,
  output logic [DATA_WIDTH-1:0] signal_offset,
  output logic                  hold_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  cal_error,
  output logic [2:0]            state_mon
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_ACCUM   = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_APPLY   = 3'd4;

  // Most negative and most positive representable offsets.
  localparam logic [DATA_WIDTH-1:0] OFF_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OFF_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [2:0]              state_q,  state_d;
  logic [4:0]              n_q,      n_d;
  logic [15:0]             settle_q, settle_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic signed [ACC_W-1:0] acc_q,    acc_d;
  logic [DATA_WIDTH-1:0]   off_q,    off_d;
  logic [DATA_WIDTH-1:0]   offset_q, offset_d;
  logic                    done_q,   done_d;

  logic [4:0]              log2_n_clamped;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W-1:0]        sample_target;
  logic signed [ACC_W-1:0] sample_ext;
  logic [DATA_WIDTH-1:0]   avg_lo;
  logic [DATA_WIDTH-1:0]   off_calc;

`ifdef CTRLSRC_CAL_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [STALL_W-1:0] stall_q, stall_d;
  logic [STALL_W-1:0] stall_inc;
  logic               err_q,   err_d;
`endif

  // Datapath helpers shared by several states.
  always_comb begin
    log2_n_clamped = (int'(log2_n) > MAX_LOG2) ? 5'(MAX_LOG2) : log2_n;
    cnt_inc        = cnt_q + CNT_W'(1);
    sample_target  = CNT_W'(1) << n_q;
    sample_ext     = {{MAX_LOG2{S_AXIS.tdata[DATA_WIDTH-1]}}, S_AXIS.tdata};
    // The average of 2^n DATA_WIDTH-bit samples always fits in DATA_WIDTH
    // bits, so only the low slice of the arithmetic shift is needed.
    avg_lo         = DATA_WIDTH'(acc_q >>> n_q);
    // Negating the most negative value is the only case that overflows.
    if (avg_lo == OFF_MIN) begin
      off_calc = OFF_MAX;
    end else begin
      off_calc = {DATA_WIDTH{1'b0}} - avg_lo;
    end
  end

`ifdef CTRLSRC_CAL_TIMEOUT_EN
  always_comb begin
    stall_inc = stall_q + STALL_W'(1);
  end
`endif

  // Sequencer next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    off_d    = off_q;
    offset_d = offset_q;
    done_d   = 1'b0;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
    stall_d  = stall_q;
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A manual write and a start in the same cycle both take effect.
        if (offset_wr) begin
          offset_d = offset_in;
        end
        if (cal_start) begin
          n_d      = log2_n_clamped;
          settle_d = settle_cycles;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = ST_HOLD;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end

      ST_HOLD: begin
        // The counter is checked before decrementing, giving S+1 cycles.
        if (cal_abort) begin
          state_d = ST_IDLE;
        end else if (settle_q == 16'd0) begin
          state_d = ST_ACCUM;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          stall_d = '0;
`endif
        end else begin
          settle_d = settle_q - 16'd1;
        end
      end

      ST_ACCUM: begin
        if (cal_abort) begin
          state_d = ST_IDLE;
        end else if (S_AXIS.tvalid) begin
          acc_d = acc_q + sample_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == sample_target) begin
            state_d = ST_COMPUTE;
          end
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          stall_d = '0;
        end else begin
          stall_d = stall_inc;
          if (stall_inc == STALL_W'(TIMEOUT_CYC)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end

      ST_COMPUTE: begin
        if (cal_abort) begin
          state_d = ST_IDLE;
        end else begin
          off_d   = off_calc;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        // Commit is unconditional here; a late abort cannot cancel it.
        offset_d = off_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge a_clk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      off_q    <= '0;
      offset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      off_q    <= off_d;
      offset_q <= offset_d;
      done_q   <= done_d;
    end
  end

`ifdef CTRLSRC_CAL_TIMEOUT_EN
  // Stall counter and sticky error flag for the timeout option.
  always_ff @(posedge a_clk) begin
    if (!aresetn) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign cal_error = err_q;
`else
  // Without the timeout option the flag never sets; TIMEOUT_CYC is a
  // positive count, so this comparison folds to a constant 0.
  assign cal_error = (TIMEOUT_CYC < 0);
`endif

  assign busy             = (state_q != ST_IDLE);
  assign hold_ctrl        = busy;
  assign done             = done_q;
  assign signal_offset    = offset_q;
  assign state_mon        = state_q;
  assign selection_ln_out = busy ? 2'b00 : selection_ln_in;

endmodule

// File: tb/tb_axis_ctrlsrc_offset_cal.sv
// ---------------------------------------------------------------------------
// tb_axis_ctrlsrc_offset_cal
//
// Purpose:
//   Self-checking bench for axis_ctrlsrc_offset_cal. A transaction-level
//   reference (running sum in a longint, floor division, saturation) predicts
//   the outputs, a negedge process compares them every cycle, and directed
//   scenarios add hand-computed literal expectations.
//   Inputs change 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_axis_ctrlsrc_offset_cal;

  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic        a_clk;
  logic        aresetn;
  logic        cal_start;
  logic        cal_abort;
  logic [4:0]  log2_n;
  logic [15:0] settle_cycles;
  logic        offset_wr;
  logic [31:0] offset_in;
  logic [1:0]  selection_ln_in;
  logic [1:0]  selection_ln_out;
  logic [31:0] signal_offset;
  logic        hold_ctrl;
  logic        busy;
  logic        done;
  logic        cal_error;
  logic [2:0]  state_mon;

  axis_ctrlsrc_offset_cal_if #(.DATA_WIDTH(DW)) axis ();

  axis_ctrlsrc_offset_cal #(
    .DATA_WIDTH (DW),
    .MAX_LOG2   (16),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .a_clk           (a_clk),
    .aresetn         (aresetn),
    .S_AXIS          (axis),
    .cal_start       (cal_start),
    .cal_abort       (cal_abort),
    .log2_n          (log2_n),
    .settle_cycles   (settle_cycles),
    .offset_wr       (offset_wr),
    .offset_in       (offset_in),
    .selection_ln_in (selection_ln_in),
    .selection_ln_out(selection_ln_out),
    .signal_offset   (signal_offset),
    .hold_ctrl       (hold_ctrl),
    .busy            (busy),
    .done            (done),
    .cal_error       (cal_error),
    .state_mon       (state_mon)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic chk_en = 1'b0;

  // Reference model state: a calibration is a window of phases, not states.
  localparam int PH_SETTLE  = 1;
  localparam int PH_COLLECT = 2;
  localparam int PH_FINISH  = 3;

  logic        m_active = 1'b0;
  int          m_phase  = 0;
  int          m_settle = 0;
  int          m_n      = 0;
  longint      m_sum    = 0;
  longint      m_cnt    = 0;
  int          m_tail   = 0;
  logic [31:0] m_off    = '0;
  logic        m_done   = 1'b0;
  logic        m_err    = 1'b0;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
  int          m_stall  = 0;
`endif

  // Offset is minus the floor of the mean, clipped to the positive limit.
  function automatic logic [31:0] expectedOffset(input longint sum, input int n);
    longint d;
    longint q;
    longint o;
    d = longint'(1) << n;
    q = sum / d;
    if (sum < 0 && q * d != sum) q = q - 1;
    o = -q;
    if (o > 64'sd2147483647) o = 64'sd2147483647;
    return o[31:0];
  endfunction

  function automatic logic [31:0] expectedState();
    if (!m_active) return 32'd0;
    if (m_phase == PH_SETTLE) return 32'd1;
    if (m_phase == PH_COLLECT) return 32'd2;
    return (m_tail == 2) ? 32'd3 : 32'd4;
  endfunction

  task automatic modelStep();
    if (!aresetn) begin
      m_active = 1'b0;
      m_off    = '0;
      m_done   = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (offset_wr) m_off = offset_in;
        if (cal_start) begin
          m_active = 1'b1;
          m_phase  = PH_SETTLE;
          m_settle = int'(settle_cycles);
          m_n      = (int'(log2_n) > 16) ? 16 : int'(log2_n);
          m_sum    = 0;
          m_cnt    = 0;
          m_err    = 1'b0;
        end
      end else if (cal_abort && !(m_phase == PH_FINISH && m_tail == 1)) begin
        m_active = 1'b0;
      end else if (m_phase == PH_SETTLE) begin
        if (m_settle == 0) begin
          m_phase = PH_COLLECT;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          m_stall = 0;
`endif
        end else begin
          m_settle = m_settle - 1;
        end
      end else if (m_phase == PH_COLLECT) begin
        if (axis.tvalid) begin
          m_sum = m_sum + longint'($signed(axis.tdata));
          m_cnt = m_cnt + 1;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          m_stall = 0;
`endif
          if (m_cnt == (longint'(1) << m_n)) begin
            m_phase = PH_FINISH;
            m_tail  = 2;
          end
        end
`ifdef CTRLSRC_CAL_TIMEOUT_EN
        else begin
          m_stall = m_stall + 1;
          if (m_stall == TIMEOUT) begin
            m_active = 1'b0;
            m_err    = 1'b1;
          end
        end
`endif
      end else begin
        if (m_tail == 2) begin
          m_tail = 1;
        end else begin
          m_off    = expectedOffset(m_sum, m_n);
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  endtask

  always @(posedge a_clk) modelStep();

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt = total_cnt + 1;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
               name, $time, actual, expected);
    end else begin
      pass_cnt = pass_cnt + 1;
    end
  endtask

  // Per-cycle comparison of every output against the reference model.
  always @(negedge a_clk) begin
    if (chk_en) begin
      checkOutput("signal_offset", signal_offset, m_off);
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("hold_ctrl", 32'(hold_ctrl), 32'(m_active));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("cal_error", 32'(cal_error), 32'(m_err));
      checkOutput("state_mon", 32'(state_mon), expectedState());
      checkOutput("selection_ln_out", 32'(selection_ln_out),
                  m_active ? 32'd0 : 32'(selection_ln_in));
    end
  end

  // Drives one cycle of inputs and advances to just after the next edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] dat,
                               input logic start, input logic abort,
                               input logic wr, input logic [31:0] wval);
    axis.tvalid = vld;
    axis.tdata  = dat;
    cal_start   = start;
    cal_abort   = abort;
    offset_wr   = wr;
    offset_in   = wval;
    @(posedge a_clk);
    #2;
  endtask

  initial begin
    aresetn         = 1'b0;
    cal_start       = 1'b0;
    cal_abort       = 1'b0;
    log2_n          = '0;
    settle_cycles   = '0;
    offset_wr       = 1'b0;
    offset_in       = '0;
    selection_ln_in = 2'b01;
    axis.tvalid     = 1'b0;
    axis.tdata      = '0;

    // Reset held for two edges.
    @(posedge a_clk);
    #2;
    chk_en = 1'b1;
    @(posedge a_clk);
    #2;
    checkOutput("rst_offset", signal_offset, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_state", 32'(state_mon), 32'd0);
    checkOutput("rst_sel", 32'(selection_ln_out), 32'd1);
    aresetn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Constant input, S=3, 16 samples: done and new offset in cycle 23.
    settle_cycles = 16'd3;
    log2_n        = 5'd4;
    applyStimulus(1'b1, 32'h0100_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 22; c++) begin
      if (c == 1 || c == 22) begin
        checkOutput("cal2_sel_busy", 32'(selection_ln_out), 32'd0);
        checkOutput("cal2_hold", 32'(hold_ctrl), 32'd1);
      end
      applyStimulus(1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("cal2_offset", signal_offset, 32'hFF00_0000);
    checkOutput("cal2_done", 32'(done), 32'd1);
    checkOutput("cal2_busy_end", 32'(busy), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("cal2_done_pulse", 32'(done), 32'd0);

    // Alternating 5,-6 averaged over 2: floor(-0.5) = -1, offset +1.
    settle_cycles = 16'd0;
    log2_n        = 5'd1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, (c % 2 == 0) ? 32'd5 : 32'hFFFF_FFFA,
                    (c == 0), 1'b0, 1'b0, 32'h0);
    end
    checkOutput("alt_offset", signal_offset, 32'h0000_0001);

    // Most negative sample saturates the negated offset.
    log2_n = 5'd0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b1, 32'h8000_0000, (c == 0), 1'b0, 1'b0, 32'h0);
    end
    checkOutput("sat_offset", signal_offset, 32'h7FFF_FFFF);

    // Sparse tvalid: samples 300,600,900,1200 -> -750; junk ignored.
    log2_n = 5'd2;
    for (int c = 0; c < 18; c++) begin
      applyStimulus((c % 3 == 0), (c % 3 == 0) ? 32'(c * 100) : 32'h7FFF_0000,
                    (c == 0), 1'b0, 1'b0, 32'h0);
    end
    checkOutput("sparse_offset", signal_offset, 32'hFFFF_FD12);

    // Manual write, then a calibration aborted in ACCUM.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("manual_offset", signal_offset, 32'h1234_5678);
    settle_cycles = 16'd1;
    log2_n        = 5'd3;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 32'h10, (c == 0), (c == 4), 1'b0, 32'h0);
    end
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_offset", signal_offset, 32'h1234_5678);
    checkOutput("abort_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Manual write while busy is ignored; calibration gives -16.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b1, 32'h10, (c == 0), 1'b0, (c == 2), 32'hAAAA_5555);
    end
    checkOutput("busy_wr_offset", signal_offset, 32'hFFFF_FFF0);

    // Write and start together, then abort in HOLD.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wr_start_offset", signal_offset, 32'h0BAD_F00D);
    checkOutput("hold_abort_state", 32'(state_mon), 32'd0);

    // Abort during APPLY loses to the commit.
    settle_cycles = 16'd0;
    log2_n        = 5'd0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 32'd7, (c == 0), (c == 4), 1'b0, 32'h0);
    end
    checkOutput("apply_abort_offset", signal_offset, 32'hFFFF_FFF9);
    checkOutput("apply_abort_done", 32'(done), 32'd1);

    // Abort during COMPUTE cancels the commit.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 32'd9, (c == 0), (c == 3), 1'b0, 32'h0);
    end
    checkOutput("compute_abort_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("compute_abort_offset", signal_offset, 32'hFFFF_FFF9);

    // Reset in the middle of ACCUM: no done, offset back to zero.
    log2_n = 5'd3;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 32'd3, (c == 0), 1'b0, 1'b0, 32'h0);
    end
    aresetn = 1'b0;
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_offset", signal_offset, 32'h0);
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    end

`ifdef CTRLSRC_CAL_TIMEOUT_EN
    // Samples stop after two; eight empty cycles time out ACCUM.
    log2_n = 5'd2;
    for (int c = 0; c < 14; c++) begin
      applyStimulus((c == 2 || c == 3), 32'd4, (c == 0), 1'b0, 1'b0, 32'h0);
    end
    checkOutput("timeout_error", 32'(cal_error), 32'd1);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_offset", signal_offset, 32'h0);
    log2_n = 5'd0;
    applyStimulus(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("timeout_clear", 32'(cal_error), 32'd0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
    end
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
